// File: rtl/uart_pkg.sv
// Shared definitions for the UART controller: register map, STATUS layout,
// TX sequencer states and the reset baud setting.
package uart_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_TXDATA = 2'd2;
  localparam logic [1:0] REG_RXDATA = 2'd3;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_FULL  = 2;
  localparam int ST_RX_EMPTY = 3;
  localparam int ST_RX_OVF   = 4;
  localparam int ST_TX_BUSY  = 5;

  localparam logic [15:0] CBP_RESET_DFLT = 16'd868;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_LOAD  = 2'd1,
    TX_SEND  = 2'd2,
    TX_CLEAR = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with first-word-fall-through head; a pop is honoured
// before a push in the same cycle, so a full FIFO can accept a push while popping.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DEPTH_C);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: contents are only visible through a non-zero count.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_ctrl.sv
// Bus-side UART controller: register file, TX/RX byte FIFOs, TX frame
// sequencer, RX done-edge capture and level interrupt.
module uart_ctrl
  import uart_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] CBP_RESET  = CBP_RESET_DFLT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [3:0]  addr_i,
  input  logic [31:0] wdata_i,
  input  logic        we_i,
  input  logic        re_i,
  output logic [31:0] rdata_o,
  output logic        rvalid_o,
  output logic        irq_o,
  output logic [15:0] cbp_o,
  output logic [1:0]  stop_bits_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_en_o,
  input  logic        tx_done_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_done_i,
  output logic        core_clr_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]  reg_sel;
  logic        wr_ctrl, wr_status, wr_txdata, rd_rxdata;

  logic [15:0] cbp_q, cbp_d;
  logic [1:0]  stop_q, stop_d;
  logic        irq_rx_en_q, irq_rx_en_d, irq_tx_en_q, irq_tx_en_d;
  logic        overflow_q, overflow_d;
  logic        rx_done_prev_q, rx_edge;
  logic        core_clr_q, core_clr_d;
  logic        irq_q, irq_d;
  logic [31:0] rdata_q, rdata_d, status_w;
  logic        rvalid_q;

  tx_state_e   state_q, state_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_pop, tx_clr_req, tx_busy;

  logic [7:0]  tx_head, rx_head;
  logic        tx_full, tx_empty, rx_full, rx_empty;
  logic [CW-1:0] tx_cnt_unused, rx_cnt_unused;
  logic        unused_w;

  assign reg_sel   = addr_i[3:2];
  assign wr_ctrl   = we_i && (reg_sel == REG_CTRL);
  assign wr_status = we_i && (reg_sel == REG_STATUS);
  assign wr_txdata = we_i && (reg_sel == REG_TXDATA);
  assign rd_rxdata = re_i && (reg_sel == REG_RXDATA);
  assign rx_edge   = rx_done_i && !rx_done_prev_q;
  assign tx_busy   = (state_q != TX_IDLE);
  assign unused_w  = ^{addr_i[1:0], wdata_i[31:20], tx_cnt_unused, rx_cnt_unused};

  uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (wr_txdata),
    .wdata_i (wdata_i[7:0]),
    .pop_i   (tx_pop),
    .rdata_o (tx_head),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_cnt_unused)
  );

  uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (rx_edge),
    .wdata_i (rx_data_i),
    .pop_i   (rd_rxdata),
    .rdata_o (rx_head),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .count_o (rx_cnt_unused)
  );

  // TX sequencer: one byte per frame, waits for the core's sticky done to clear.
  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    tx_pop     = 1'b0;
    tx_clr_req = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (!tx_empty && !tx_done_i) begin
          tx_pop    = 1'b1;
          tx_data_d = tx_head;
          state_d   = TX_LOAD;
        end
      end
      TX_LOAD: state_d = TX_SEND;
      TX_SEND: begin
        if (tx_done_i) begin
          tx_clr_req = 1'b1;
          state_d    = TX_CLEAR;
        end
      end
      TX_CLEAR: begin
        if (!tx_done_i) state_d = TX_IDLE;
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    cbp_d       = cbp_q;
    stop_d      = stop_q;
    irq_rx_en_d = irq_rx_en_q;
    irq_tx_en_d = irq_tx_en_q;
    if (wr_ctrl) begin
      cbp_d       = wdata_i[15:0];
      stop_d      = wdata_i[17:16];
      irq_rx_en_d = wdata_i[18];
      irq_tx_en_d = wdata_i[19];
    end
    // A new overflow in the same cycle as the W1C wins so no drop goes unreported.
    overflow_d = overflow_q;
    if (wr_status && wdata_i[ST_RX_OVF]) overflow_d = 1'b0;
    if (rx_edge && rx_full && !rd_rxdata) overflow_d = 1'b1;

    core_clr_d = tx_clr_req || rx_edge;
    irq_d      = (irq_rx_en_q && !rx_empty) || (irq_tx_en_q && tx_empty && !tx_busy);

    status_w              = '0;
    status_w[ST_TX_FULL]  = tx_full;
    status_w[ST_TX_EMPTY] = tx_empty;
    status_w[ST_RX_FULL]  = rx_full;
    status_w[ST_RX_EMPTY] = rx_empty;
    status_w[ST_RX_OVF]   = overflow_q;
    status_w[ST_TX_BUSY]  = tx_busy;

    rdata_d = '0;
    if (re_i) begin
      case (reg_sel)
        REG_CTRL:   rdata_d = {12'h0, irq_tx_en_q, irq_rx_en_q, stop_q, cbp_q};
        REG_STATUS: rdata_d = status_w;
        REG_RXDATA: rdata_d = rx_empty ? 32'h0 : {24'h0, rx_head};
        default:    rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= TX_IDLE;
      tx_data_q      <= '0;
      cbp_q          <= CBP_RESET;
      stop_q         <= '0;
      irq_rx_en_q    <= 1'b0;
      irq_tx_en_q    <= 1'b0;
      overflow_q     <= 1'b0;
      rx_done_prev_q <= 1'b0;
      core_clr_q     <= 1'b0;
      irq_q          <= 1'b0;
      rdata_q        <= '0;
      rvalid_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      tx_data_q      <= tx_data_d;
      cbp_q          <= cbp_d;
      stop_q         <= stop_d;
      irq_rx_en_q    <= irq_rx_en_d;
      irq_tx_en_q    <= irq_tx_en_d;
      overflow_q     <= overflow_d;
      rx_done_prev_q <= rx_done_i;
      core_clr_q     <= core_clr_d;
      irq_q          <= irq_d;
      rdata_q        <= rdata_d;
      rvalid_q       <= re_i;
    end
  end

  assign tx_en_o     = (state_q == TX_LOAD) || (state_q == TX_SEND);
  assign tx_data_o   = tx_data_q;
  assign cbp_o       = cbp_q;
  assign stop_bits_o = stop_q;
  assign core_clr_o  = core_clr_q;
  assign irq_o       = irq_q;
  assign rdata_o     = rdata_q;
  assign rvalid_o    = rvalid_q;

endmodule

// File: tb/tb_uart_ctrl.sv
// Directed bench for uart_ctrl with a small behavioural UART core model
// (fixed-length TX frames, sticky done flags cleared by core_clr_o).
module tb_uart_ctrl;

  localparam int FRAME = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic        we, re;
  logic [31:0] rdata;
  logic        rvalid, irq;
  logic [15:0] cbp;
  logic [1:0]  stop_bits;
  logic [7:0]  tx_data;
  logic        tx_en, tx_done;
  logic [7:0]  rx_data;
  logic        rx_done, core_clr;

  // core model state
  logic        tx_done_q = 1'b0, rx_done_q = 1'b0;
  logic [7:0]  rx_data_q = 8'h0;
  int          frame_cnt = 0;
  logic        stall = 1'b0;
  logic        rx_req = 1'b0;
  logic [7:0]  rx_byte = 8'h0;
  logic [7:0]  sent_q[$];

  // monitor state
  int   clr_cnt = 0;
  int   en_bad  = 0;
  logic en_prev = 1'b0, done_prev = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  assign tx_done = tx_done_q | stall;
  assign rx_done = rx_done_q;
  assign rx_data = rx_data_q;

  uart_ctrl #(.FIFO_DEPTH(8), .CBP_RESET(16'd868)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .we_i        (we),
    .re_i        (re),
    .rdata_o     (rdata),
    .rvalid_o    (rvalid),
    .irq_o       (irq),
    .cbp_o       (cbp),
    .stop_bits_o (stop_bits),
    .tx_data_o   (tx_data),
    .tx_en_o     (tx_en),
    .tx_done_i   (tx_done),
    .rx_data_i   (rx_data),
    .rx_done_i   (rx_done),
    .core_clr_o  (core_clr)
  );

  always @(posedge clk) begin
    if (rst) begin
      tx_done_q <= 1'b0;
      rx_done_q <= 1'b0;
      frame_cnt <= 0;
    end else begin
      if (core_clr) begin
        tx_done_q <= 1'b0;
        rx_done_q <= 1'b0;
      end
      if (tx_en && !tx_done_q && !stall) begin
        if (frame_cnt == FRAME-1) begin
          tx_done_q <= 1'b1;
          frame_cnt <= 0;
          sent_q.push_back(tx_data);
        end else begin
          frame_cnt <= frame_cnt + 1;
        end
      end
      if (rx_req && !rx_done_q) begin
        rx_done_q <= 1'b1;
        rx_data_q <= rx_byte;
      end
    end
  end

  always @(negedge clk) begin
    if (core_clr) clr_cnt++;
    if (!rst && en_prev && !tx_en && !done_prev) en_bad++;
    en_prev   = tx_en;
    done_prev = tx_done;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wdata = d; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [3:0] a, input logic [31:0] exp);
    @(negedge clk);
    addr = a; re = 1'b1;
    @(negedge clk);
    re = 1'b0;
    check({tag, "_rvalid"}, {31'h0, rvalid}, 32'h1);
    check(tag, rdata, exp);
  endtask

  task automatic wait_sent(input int n, input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (sent_q.size() >= n) break;
      @(negedge clk);
    end
  endtask

  task automatic rx_send(input logic [7:0] b);
    for (int i = 0; i < 50; i++) begin
      if (!rx_done_q) break;
      @(negedge clk);
    end
    check("rx_core_ready", {31'h0, rx_done_q}, 32'h0);
    rx_byte = b; rx_req = 1'b1;
    @(negedge clk);
    rx_req = 1'b0;
    idle(4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int saved;
    rst = 1'b1; addr = '0; wdata = '0; we = 1'b0; re = 1'b0;
    idle(3);
    check("rst_cbp", {16'h0, cbp}, 32'd868);
    check("rst_stop", {30'h0, stop_bits}, 32'h0);
    check("rst_tx_en", {31'h0, tx_en}, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    check("rst_clr", {31'h0, core_clr}, 32'h0);
    check("rst_rvalid", {31'h0, rvalid}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    rst = 1'b0;
    idle(1);
    read_check("rst_status", 4'h4, 32'h0000_000A);

    // CTRL write/readback, tx-empty interrupt
    bus_write(4'h0, 32'h000A_0123);
    check("ctrl_cbp", {16'h0, cbp}, 32'h0000_0123);
    check("ctrl_stop", {30'h0, stop_bits}, 32'h2);
    read_check("ctrl_rd", 4'h0, 32'h000A_0123);
    idle(2);
    check("irq_tx_on", {31'h0, irq}, 32'h1);
    bus_write(4'h0, 32'h0000_0364);
    idle(2);
    check("irq_tx_off", {31'h0, irq}, 32'h0);

    // two-byte transmit
    saved = clr_cnt;
    bus_write(4'h8, 32'h0000_0055);
    bus_write(4'h8, 32'h0000_00A3);
    wait_sent(2, 200);
    idle(10);
    check("tx2_count", sent_q.size(), 32'd2);
    if (sent_q.size() >= 2) begin
      check("tx2_byte0", {24'h0, sent_q[0]}, 32'h55);
      check("tx2_byte1", {24'h0, sent_q[1]}, 32'hA3);
    end
    check("tx2_clr_pulses", clr_cnt - saved, 32'd2);
    read_check("tx2_status", 4'h4, 32'h0000_000A);

    // fill TX FIFO while the core is stalled; 9th write dropped
    sent_q.delete();
    @(negedge clk);
    stall = 1'b1;
    for (int i = 0; i < 9; i++) bus_write(4'h8, 32'h10 + i);
    read_check("full_status", 4'h4, 32'h0000_0009);
    @(negedge clk);
    stall = 1'b0;
    wait_sent(8, 400);
    idle(40);
    check("full_count", sent_q.size(), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < sent_q.size()) check($sformatf("full_byte%0d", i), {24'h0, sent_q[i]}, 32'h10 + i);
    end
    read_check("full_drain_status", 4'h4, 32'h0000_000A);
    check("tx_en_hold", en_bad, 32'd0);

    // single RX byte with rx interrupt
    bus_write(4'h0, 32'h0004_0364);
    rx_send(8'h3C);
    check("irq_rx_on", {31'h0, irq}, 32'h1);
    read_check("rx_byte", 4'hC, 32'h0000_003C);
    @(negedge clk);
    check("rvalid_pulse", {31'h0, rvalid}, 32'h0);
    idle(1);
    check("irq_rx_off", {31'h0, irq}, 32'h0);

    // RX overflow
    for (int i = 0; i < 9; i++) rx_send(8'h81 + 8'(i));
    read_check("ovf_status", 4'h4, 32'h0000_0016);
    for (int i = 0; i < 8; i++) read_check($sformatf("ovf_rd%0d", i), 4'hC, 32'h81 + i);
    read_check("ovf_sticky", 4'h4, 32'h0000_001A);
    bus_write(4'h4, 32'h0000_0010);
    read_check("ovf_w1c", 4'h4, 32'h0000_000A);
    read_check("rx_empty_rd", 4'hC, 32'h0000_0000);

    // reset in the middle of a frame
    bus_write(4'h0, 32'h0001_0100);
    rx_send(8'h42);
    saved = sent_q.size();
    bus_write(4'h8, 32'h77);
    bus_write(4'h8, 32'h78);
    for (int i = 0; i < 50; i++) begin
      if (tx_en) break;
      @(negedge clk);
    end
    check("pre_rst_tx_en", {31'h0, tx_en}, 32'h1);
    idle(1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_tx_en", {31'h0, tx_en}, 32'h0);
    check("mid_rst_cbp", {16'h0, cbp}, 32'd868);
    check("mid_rst_stop", {30'h0, stop_bits}, 32'h0);
    check("mid_rst_irq", {31'h0, irq}, 32'h0);
    rst = 1'b0;
    idle(1);
    read_check("mid_rst_status", 4'h4, 32'h0000_000A);
    read_check("mid_rst_ctrl", 4'h0, 32'h0000_0364);
    idle(40);
    check("mid_rst_no_send", sent_q.size(), saved);
    check("mid_rst_tx_idle", {31'h0, tx_en}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
